// File: rtl/cam_capture_pkg.sv
// Shared types and default widths for the camera DVP capture front end.
package cam_capture_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_CNT_W  = 17;
    localparam int unsigned DEF_LINE_W = 11;

    localparam bit VSYNC_ACT_HIGH = 1'b1;
    localparam bit VSYNC_ACT_LOW  = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        SYNC   = 2'd2,
        ACTIVE = 2'd3
    } cap_state_e;

endpackage

// File: rtl/cam_sync_edge.sv
// Registers one camera control pin and reports its active level plus rise/fall
// of that active level, relative to ACT_LEVEL polarity.
module cam_sync_edge #(
    parameter bit ACT_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic level_c_o,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic s_q;
    logic p_q;

    // Reset to the inactive level so no edge is reported right after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q <= ~ACT_LEVEL;
            p_q <= ~ACT_LEVEL;
        end else begin
            s_q <= pin_i;
            p_q <= s_q;
        end
    end

    assign level_c_o = (s_q == ACT_LEVEL);
    assign rise_c_o  = (s_q == ACT_LEVEL) && (p_q != ACT_LEVEL);
    assign fall_c_o  = (s_q != ACT_LEVEL) && (p_q == ACT_LEVEL);

endmodule

// File: rtl/cam_capture.sv
// Single-shot DVP frame capture with byte budget, feeding the frame dump buffer.
// Optional capture window enabled by defining CAM_CAPTURE_WINDOW_EN.
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned LINE_W    = DEF_LINE_W,
    parameter bit          VSYNC_POL = VSYNC_ACT_HIGH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              armStart,
    input  logic              abort,
    input  logic [CNT_W-1:0]  byteLimit,
    input  logic              camVsync,
    input  logic              camHref,
    input  logic [DATA_W-1:0] camData,
`ifdef CAM_CAPTURE_WINDOW_EN
    input  logic [CNT_W-1:0]  winXStart,
    input  logic [CNT_W-1:0]  winXEnd,
    input  logic [LINE_W-1:0] winYStart,
    input  logic [LINE_W-1:0] winYEnd,
`endif
    output logic              busy,
    output logic              frameStart,
    output logic              frameEnd,
    output logic              writeEn,
    output logic [DATA_W-1:0] writeData,
    output logic [CNT_W-1:0]  byteCount,
    output logic [LINE_W-1:0] lineCount,
    output logic              overflow
);

    cap_state_e        state_q, state_d;
    logic              busy_q, busy_d;
    logic              fs_q, fs_d;
    logic              fe_q, fe_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [CNT_W-1:0]  bc_q, bc_d;
    logic [LINE_W-1:0] lc_q, lc_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] sD_q;

    logic vs_act, vs_rise, vs_fall;
    logic sH, href_rise, unused_href_fall;
    logic byte_ok;
    logic limit_hit;

    cam_sync_edge #(.ACT_LEVEL(VSYNC_POL)) u_vsync (
        .clk       (clk),
        .reset_n   (reset_n),
        .pin_i     (camVsync),
        .level_c_o (vs_act),
        .rise_c_o  (vs_rise),
        .fall_c_o  (vs_fall)
    );

    cam_sync_edge #(.ACT_LEVEL(1'b1)) u_href (
        .clk       (clk),
        .reset_n   (reset_n),
        .pin_i     (camHref),
        .level_c_o (sH),
        .rise_c_o  (href_rise),
        .fall_c_o  (unused_href_fall)
    );

    // Data rides alongside the HREF sample so byte and strobe stay aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sD_q <= '0;
        else          sD_q <= camData;
    end

    assign limit_hit = (byteLimit != '0) && (bc_q == byteLimit);

`ifdef CAM_CAPTURE_WINDOW_EN
    logic [CNT_W-1:0]  x_q, x_d, x_idx;
    logic [LINE_W-1:0] line_eff, y_idx;

    // Index of the byte currently in sD; a new line restarts at column 0.
    assign x_idx    = href_rise ? '0 : x_q;
    assign line_eff = (href_rise && (lc_q != '1)) ? lc_q + LINE_W'(1) : lc_q;
    assign y_idx    = line_eff - LINE_W'(1);
    assign byte_ok  = (x_idx >= winXStart) && (x_idx <= winXEnd) &&
                      (y_idx >= winYStart) && (y_idx <= winYEnd);

    always_comb begin
        x_d = x_q;
        if ((state_q == ACTIVE) && !abort && !vs_rise && sH)
            x_d = (x_idx == '1) ? x_idx : x_idx + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) x_q <= '0;
        else          x_q <= x_d;
    end
`else
    assign byte_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            bc_q    <= '0;
            lc_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            bc_q    <= bc_d;
            lc_q    <= lc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        fs_d    = 1'b0;
        fe_d    = 1'b0;
        we_d    = 1'b0;
        wd_d    = wd_q;
        bc_d    = bc_q;
        lc_d    = lc_q;
        ovf_d   = ovf_q;

        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (armStart) begin
                        state_d = ARM;
                        busy_d  = 1'b1;
                        bc_d    = '0;
                        lc_d    = '0;
                        ovf_d   = 1'b0;
                    end
                end
                ARM: begin
                    if (vs_act) state_d = SYNC;
                end
                SYNC: begin
                    if (vs_fall) begin
                        state_d = ACTIVE;
                        fs_d    = 1'b1;
                    end
                end
                ACTIVE: begin
                    // A byte coinciding with the closing VSYNC edge is dropped.
                    if (vs_rise) begin
                        state_d = IDLE;
                        fe_d    = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        if (href_rise && (lc_q != '1)) lc_d = lc_q + LINE_W'(1);
                        if (sH && byte_ok) begin
                            if (limit_hit) begin
                                ovf_d = 1'b1;
                            end else begin
                                we_d = 1'b1;
                                wd_d = sD_q;
                                if (bc_q != '1) bc_d = bc_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign frameStart = fs_q;
    assign frameEnd   = fe_q;
    assign writeEn    = we_q;
    assign writeData  = wd_q;
    assign byteCount  = bc_q;
    assign lineCount  = lc_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed self-checking bench for cam_capture (window cases when
// CAM_CAPTURE_WINDOW_EN is defined).
module tb_cam_capture;
    import cam_capture_pkg::*;

    localparam int unsigned DATA_W = DEF_DATA_W;
    localparam int unsigned CNT_W  = DEF_CNT_W;
    localparam int unsigned LINE_W = DEF_LINE_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              armStart;
    logic              abort;
    logic [CNT_W-1:0]  byteLimit;
    logic              camVsync;
    logic              camHref;
    logic [DATA_W-1:0] camData;
`ifdef CAM_CAPTURE_WINDOW_EN
    logic [CNT_W-1:0]  winXStart, winXEnd;
    logic [LINE_W-1:0] winYStart, winYEnd;
`endif
    logic              busy, frameStart, frameEnd, writeEn, overflow;
    logic [DATA_W-1:0] writeData;
    logic [CNT_W-1:0]  byteCount;
    logic [LINE_W-1:0] lineCount;

    cam_capture #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .LINE_W    (LINE_W),
        .VSYNC_POL (VSYNC_ACT_HIGH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .armStart   (armStart),
        .abort      (abort),
        .byteLimit  (byteLimit),
        .camVsync   (camVsync),
        .camHref    (camHref),
        .camData    (camData),
`ifdef CAM_CAPTURE_WINDOW_EN
        .winXStart  (winXStart),
        .winXEnd    (winXEnd),
        .winYStart  (winYStart),
        .winYEnd    (winYEnd),
`endif
        .busy       (busy),
        .frameStart (frameStart),
        .frameEnd   (frameEnd),
        .writeEn    (writeEn),
        .writeData  (writeData),
        .byteCount  (byteCount),
        .lineCount  (lineCount),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records every write and pulse seen at the falling edge.
    logic [7:0] wr_q[$];
    int         wc_q[$];
    int         fs_cnt = 0;
    int         fe_cnt = 0;
    always @(negedge clk) begin
        if (writeEn === 1'b1) begin
            wr_q.push_back(writeData);
            wc_q.push_back(cyc);
        end
        if (frameStart === 1'b1) fs_cnt++;
        if (frameEnd === 1'b1)   fe_cnt++;
    end

    int  checks = 0;
    int  errors = 0;
    int  dc_q[$];
    bit  rec_lat = 1'b0;
    int  wr_b, fs_b, fe_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        wr_b = wr_q.size();
        fs_b = fs_cnt;
        fe_b = fe_cnt;
    endtask

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        camVsync = v;
        camHref  = h;
        camData  = d;
        if (h && rec_lat) dc_q.push_back(cyc);
        @(negedge clk);
    endtask

    task automatic idle_vs(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic vs_pulse();
        idle_vs(3);
    endtask

    task automatic frame_lines(input int nl, input int bpl, input logic [7:0] d0);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < bpl; b++) drive(1'b0, 1'b1, d0 + 8'(l * bpl + b));
            drive(1'b0, 1'b0, 8'h00);
            drive(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic arm_pulse();
        armStart = 1'b1;
        drive(1'b1, 1'b0, 8'h00);
        armStart = 1'b0;
    endtask

    task automatic check_seq(input string tag, input logic [7:0] d0, input int n);
        check({tag, "_count"}, 32'(wr_q.size() - wr_b), 32'(n));
        for (int i = 0; i < n; i++)
            if (wr_b + i < wr_q.size())
                check($sformatf("%s[%0d]", tag, i), 32'(wr_q[wr_b + i]), 32'(d0 + 8'(i)));
    endtask

    initial begin
        int lat_bad;
        reset_n   = 1'b0;
        armStart  = 1'b0;
        abort     = 1'b0;
        byteLimit = '0;
        camVsync  = 1'b1;
        camHref   = 1'b0;
        camData   = '0;
`ifdef CAM_CAPTURE_WINDOW_EN
        winXStart = '0;
        winXEnd   = '1;
        winYStart = '0;
        winYEnd   = '1;
`endif
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_writeEn", 32'(writeEn), 32'h0);
        check("rst_frameStart", 32'(frameStart), 32'h0);
        check("rst_frameEnd", 32'(frameEnd), 32'h0);
        check("rst_byteCount", 32'(byteCount), 32'h0);
        check("rst_lineCount", 32'(lineCount), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        reset_n = 1'b1;
        idle_vs(2);

        // Full 4x6 frame, armed while VSYNC is high.
        mark();
        rec_lat = 1'b1;
        arm_pulse();
        check("t1_busy_armed", 32'(busy), 32'h1);
        idle_vs(2);
        frame_lines(4, 6, 8'h10);
        vs_pulse();
        idle_vs(3);
        rec_lat = 1'b0;
        check_seq("t1_data", 8'h10, 24);
        lat_bad = 0;
        for (int i = 0; i < dc_q.size(); i++)
            if ((wr_b + i >= wc_q.size()) || (wc_q[wr_b + i] != dc_q[i] + 2)) lat_bad++;
        check("t1_latency_bad", 32'(lat_bad), 32'h0);
        check("t1_frameStart", 32'(fs_cnt - fs_b), 32'h1);
        check("t1_frameEnd", 32'(fe_cnt - fe_b), 32'h1);
        check("t1_byteCount", 32'(byteCount), 32'd24);
        check("t1_lineCount", 32'(lineCount), 32'd4);
        check("t1_overflow", 32'(overflow), 32'h0);
        check("t1_busy_done", 32'(busy), 32'h0);

        // Arm in the middle of a frame: only the next complete frame is taken.
        mark();
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'hA0);
        armStart = 1'b1;
        drive(1'b0, 1'b1, 8'hA1);
        armStart = 1'b0;
        drive(1'b0, 1'b1, 8'hA2);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        for (int b = 0; b < 4; b++) drive(1'b0, 1'b1, 8'hA8 + 8'(b));
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("t2_no_midframe_write", 32'(wr_q.size() - wr_b), 32'h0);
        vs_pulse();
        frame_lines(2, 5, 8'h40);
        vs_pulse();
        frame_lines(1, 3, 8'h80);
        vs_pulse();
        idle_vs(3);
        check_seq("t2_data", 8'h40, 10);
        check("t2_frameStart", 32'(fs_cnt - fs_b), 32'h1);
        check("t2_frameEnd", 32'(fe_cnt - fe_b), 32'h1);
        check("t2_lineCount", 32'(lineCount), 32'd2);
        check("t2_byteCount", 32'(byteCount), 32'd10);

        // Byte budget of 10 on a 24-byte frame.
        byteLimit = CNT_W'(10);
        mark();
        arm_pulse();
        idle_vs(2);
        frame_lines(4, 6, 8'h10);
        vs_pulse();
        idle_vs(3);
        check_seq("t3_data", 8'h10, 10);
        check("t3_byteCount", 32'(byteCount), 32'd10);
        check("t3_overflow", 32'(overflow), 32'h1);
        check("t3_frameEnd", 32'(fe_cnt - fe_b), 32'h1);
        check("t3_lineCount", 32'(lineCount), 32'd4);

        // Abort after two lines; counters and overflow hold.
        mark();
        arm_pulse();
        check("t4_arm_clr_ovf", 32'(overflow), 32'h0);
        check("t4_arm_clr_bc", 32'(byteCount), 32'h0);
        idle_vs(2);
        frame_lines(2, 6, 8'h50);
        abort = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        abort = 1'b0;
        check("t4_busy_after_abort", 32'(busy), 32'h0);
        for (int b = 0; b < 6; b++) drive(1'b0, 1'b1, 8'h5C + 8'(b));
        drive(1'b0, 1'b0, 8'h00);
        vs_pulse();
        idle_vs(3);
        check_seq("t4_data", 8'h50, 10);
        check("t4_frameEnd", 32'(fe_cnt - fe_b), 32'h0);
        check("t4_byteCount", 32'(byteCount), 32'd10);
        check("t4_lineCount", 32'(lineCount), 32'd2);
        check("t4_overflow_held", 32'(overflow), 32'h1);

        // Re-arm clears counters; a repeated arm mid-frame is ignored.
        byteLimit = '0;
        mark();
        arm_pulse();
        check("t5_busy", 32'(busy), 32'h1);
        check("t5_clr_bc", 32'(byteCount), 32'h0);
        check("t5_clr_lc", 32'(lineCount), 32'h0);
        check("t5_clr_ovf", 32'(overflow), 32'h0);
        idle_vs(2);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < 4; l++) begin
            for (int b = 0; b < 6; b++) begin
                armStart = (l == 1 && b == 2);
                drive(1'b0, 1'b1, 8'h60 + 8'(l * 6 + b));
                armStart = 1'b0;
            end
            drive(1'b0, 1'b0, 8'h00);
            drive(1'b0, 1'b0, 8'h00);
        end
        vs_pulse();
        idle_vs(3);
        check_seq("t5_data", 8'h60, 24);
        check("t5_byteCount", 32'(byteCount), 32'd24);
        check("t5_frameEnd", 32'(fe_cnt - fe_b), 32'h1);

        // armStart together with abort: abort wins, idle or busy.
        armStart = 1'b1;
        abort    = 1'b1;
        drive(1'b1, 1'b0, 8'h00);
        armStart = 1'b0;
        abort    = 1'b0;
        check("t6_both_from_idle", 32'(busy), 32'h0);
        arm_pulse();
        check("t6_busy", 32'(busy), 32'h1);
        armStart = 1'b1;
        abort    = 1'b1;
        drive(1'b1, 1'b0, 8'h00);
        armStart = 1'b0;
        abort    = 1'b0;
        check("t6_both_from_busy", 32'(busy), 32'h0);
        mark();
        idle_vs(2);
        frame_lines(2, 4, 8'h70);
        vs_pulse();
        idle_vs(3);
        check("t6_no_writes", 32'(wr_q.size() - wr_b), 32'h0);
        check("t6_no_frameStart", 32'(fs_cnt - fs_b), 32'h0);
        check("t6_no_frameEnd", 32'(fe_cnt - fe_b), 32'h0);

        // Reset in the middle of an active line.
        arm_pulse();
        idle_vs(2);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        for (int b = 0; b < 3; b++) drive(1'b0, 1'b1, 8'h90 + 8'(b));
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 8'h93);
        check("t7_rst_busy", 32'(busy), 32'h0);
        check("t7_rst_writeEn", 32'(writeEn), 32'h0);
        check("t7_rst_byteCount", 32'(byteCount), 32'h0);
        check("t7_rst_lineCount", 32'(lineCount), 32'h0);
        reset_n = 1'b1;
        mark();
        drive(1'b0, 1'b1, 8'h94);
        drive(1'b0, 1'b0, 8'h00);
        vs_pulse();
        frame_lines(1, 4, 8'hB0);
        vs_pulse();
        idle_vs(3);
        check("t7_no_writes", 32'(wr_q.size() - wr_b), 32'h0);
        check("t7_no_frameStart", 32'(fs_cnt - fs_b), 32'h0);
        check("t7_no_frameEnd", 32'(fe_cnt - fe_b), 32'h0);

`ifdef CAM_CAPTURE_WINDOW_EN
        // Window X 1..3, Y 1..2 on a 4x6 frame.
        winXStart = CNT_W'(1);
        winXEnd   = CNT_W'(3);
        winYStart = LINE_W'(1);
        winYEnd   = LINE_W'(2);
        mark();
        arm_pulse();
        idle_vs(2);
        frame_lines(4, 6, 8'h10);
        vs_pulse();
        idle_vs(3);
        check("t8_count", 32'(wr_q.size() - wr_b), 32'd6);
        begin
            logic [7:0] exp_w [6];
            exp_w = '{8'h17, 8'h18, 8'h19, 8'h1D, 8'h1E, 8'h1F};
            for (int i = 0; i < 6; i++)
                if (wr_b + i < wr_q.size())
                    check($sformatf("t8_data[%0d]", i), 32'(wr_q[wr_b + i]), 32'(exp_w[i]));
        end
        check("t8_byteCount", 32'(byteCount), 32'd6);
        check("t8_lineCount", 32'(lineCount), 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Camera pixel-port front end in the camera PCLK domain.
- Sits directly upstream of the frame dump buffer.
- Samples the parallel DVP bus (VSYNC/HREF/D[7:0]) and, after a single-shot arm, captures exactly one complete frame.
- Produces frameStart/frameEnd pulses and a byte-write strobe with data for the dump buffer write port.
- Enforces a byte budget so the buffer is never overrun.

Parameters:
- DATA_W, 8: camera data and writeData width.
- CNT_W, 17: width of byteCount and byteLimit.
- LINE_W, 11: width of lineCount and the line index.
- VSYNC_POL, 1: 1 = VSYNC active-high (frame blanking while high); 0 = active-low.

Ports:
- clk  in  1  camera pixel clock (PCLK); all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- armStart  in  1  one-cycle pulse; requests capture of the next full frame.
- abort  in  1  one-cycle pulse; cancels capture.
- byteLimit  in  CNT_W  maximum bytes to write; 0 = unlimited.
- camVsync  in  1  camera VSYNC pin.
- camHref  in  1  camera HREF pin.
- camData  in  DATA_W  camera data pins.
- busy  out  1  high from accepted arm until DONE/abort.
- frameStart  out  1  one-cycle pulse at frame begin.
- frameEnd  out  1  one-cycle pulse at frame end.
- writeEn  out  1  one-cycle write strobe.
- writeData  out  DATA_W  byte valid when writeEn=1.
- byteCount  out  CNT_W  bytes written this capture (saturating).
- lineCount  out  LINE_W  HREF rising edges seen in ACTIVE.
- overflow  out  1  sticky; a byte was dropped because of byteLimit.

Behaviour:
- Input stage: camVsync, camHref and camData are registered once (sV, sH, sD). A second register on sV/sH gives edge detection. vsAct = (sV == VSYNC_POL).
- Latency: a pin value sampled at edge k appears on writeEn/writeData at edge k+1.
- Reset: all outputs 0; state IDLE; counters 0.
- States:
  - IDLE → ARM on armStart. On that transition byteCount, lineCount and overflow clear, and busy is set.
  - ARM waits for vsAct to be observed high, so capture never begins mid-frame. If vsAct is already high at arm, it is satisfied immediately → SYNC.
  - SYNC → ACTIVE on the vsAct falling edge. frameStart pulses on the following edge.
  - ACTIVE: each cycle with sH=1 (not the transition cycle) writes sD. If byteLimit != 0 and byteCount == byteLimit, writeEn is suppressed and overflow is set instead. An sH rising edge increments lineCount, saturating at all-ones.
  - ACTIVE → IDLE on the vsAct rising edge. frameEnd pulses; busy drops on the same edge as frameEnd. If sH=1 in the edge cycle, that byte is ignored.
- abort in any state → IDLE next edge. No frameEnd is issued. Counters hold their values; overflow holds.
- armStart while busy is ignored. armStart and abort in the same cycle: abort wins, state stays/returns to IDLE.
- byteCount saturates at 2^CNT_W−1. writeEn is never asserted outside ACTIVE.
- Reset mid-frame: immediate return to reset values. No partial pulses are emitted after reset release.

Optional Feature:
- Macro: CAM_CAPTURE_WINDOW_EN.
- Defined:
  - Adds inputs winXStart, winXEnd (CNT_W) and winYStart, winYEnd (LINE_W).
  - A per-line byte index resets to 0 at each sH rising edge. The line index equals lineCount−1.
  - A byte is written only if xIdx ∈ [winXStart, winXEnd] and yIdx ∈ [winYStart, winYEnd], inclusive.
  - If start > end, nothing is written in that axis.
  - byteLimit applies to windowed bytes only.
- Undefined: the window ports are absent and every HREF byte in ACTIVE is eligible.

Decomposition:
- Shared package cam_capture_pkg holds:
  - State enum {IDLE, ARM, SYNC, ACTIVE}.
  - Default widths CNT_W/LINE_W/DATA_W.
  - VSYNC polarity constants.
- One sub-module, cam_sync_edge: the input register plus edge detector for VSYNC/HREF. It outputs level, rise and fall.

Test Plan:
- Reset then arm while VSYNC high; frame of 4 lines × 6 HREF bytes (0x10..0x27) → frameStart once; 24 writeEn with data 0x10..0x27 in order, each 2 edges after the pin; frameEnd once; byteCount=24; lineCount=4; overflow=0.
- Arm mid-frame (VSYNC low, HREF toggling) → no writes until after the next VSYNC pulse; exactly one full following frame is captured.
- byteLimit=10 with a 24-byte frame → exactly 10 writes; byteCount=10; overflow=1; frameEnd still pulses.
- abort after 2 lines → busy=0 next edge; no frameEnd; no further writeEn; a subsequent arm clears counters and overflow.
- armStart repeated while busy, and armStart+abort in the same cycle → the repeat is ignored; abort wins and the block is IDLE.
- With CAM_CAPTURE_WINDOW_EN: window X 1..3, Y 1..2 on a 4×6 frame → 6 writes, bytes at (x1..3, y1..2) only.
